panel_switches: RTL and testbench

PANEL_SWITCHES -- requirements
Module: panel_switches

---
 rtl/pdp8_panel_pkg.sv | 21 ++
 rtl/debouncer.sv | 45 ++++
 rtl/panel_switches.sv | 146 ++++++++++++++
 tb/tb_panel_switches.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pdp8_panel_pkg.sv
// Shared definitions for the PDP-8 front-panel switch block: default timing
// parameters and the reset-sequencer state encoding.
package pdp8_panel_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES  = 1024;
    localparam int unsigned DEF_LONGPRESS_CYCLES = 65536;
    localparam int unsigned DEF_RESET_CYCLES     = 16;
    localparam int unsigned DEF_CLEAR_CYCLES     = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRst     = 2'd1,
        StClr     = 2'd2,
        StWaitRel = 2'd3
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer for an active-low button pin followed by a mismatch
// counter; the active-high debounced level only moves after a sustained change.
module debouncer
    import pdp8_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_level
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             w_synced;

    assign w_synced = ~r_sync_n[1];

    // Sync flops reset to the released (high) pin level so reset reads as released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_n <= 2'b11;
            r_cnt    <= '0;
            r_level  <= 1'b0;
        end else begin
            r_sync_n <= {r_sync_n[0], i_btn_n};
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/panel_switches.sv
// Front-panel RUN/HALT and RESET/CLEAR switch logic: debounced buttons, a
// long-press detector on BUT1 and a reset/clear sequencer driven by BUT2.
module panel_switches
    import pdp8_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES,
    parameter int unsigned RESET_CYCLES     = DEF_RESET_CYCLES,
    parameter int unsigned CLEAR_CYCLES     = DEF_CLEAR_CYCLES
) (
    input  logic SYSCLK,
    input  logic nRESET,
    input  logic nBUT1,
    input  logic nBUT2,
    output logic sw_RUN,
    output logic sw_HALT,
    output logic sw_RESET,
    output logic sw_CLEAR,
    output logic busy
);

    localparam int unsigned      HOLD_W   = $clog2(LONGPRESS_CYCLES) + 1;
    localparam int unsigned      SEQ_W    = $clog2(max_u(RESET_CYCLES, CLEAR_CYCLES)) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONGPRESS_CYCLES);
    localparam logic [SEQ_W-1:0]  RST_LAST = SEQ_W'(RESET_CYCLES - 1);
    localparam logic [SEQ_W-1:0]  CLR_LAST = SEQ_W'(CLEAR_CYCLES - 1);

    logic              w_but1, w_but2;
    logic              r_but1_prev, r_but2_prev;
    logic [HOLD_W-1:0] r_hold;
    logic              r_halt_done;
    logic              w_but1_fall, w_but2_rise, w_run_evt, w_halt_evt, w_idle_stays;
    seq_state_e        r_state, w_state_next;
    logic [SEQ_W-1:0]  r_seq_cnt, w_seq_cnt_next;
    logic              r_run, r_halt, r_reset, r_clear, r_busy;
    logic              w_run_next, w_halt_next, w_reset_next, w_clear_next, w_busy_next;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_but1 (
        .i_clk   (SYSCLK),
        .i_rst_n (nRESET),
        .i_btn_n (nBUT1),
        .o_level (w_but1)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_but2 (
        .i_clk   (SYSCLK),
        .i_rst_n (nRESET),
        .i_btn_n (nBUT2),
        .o_level (w_but2)
    );

    assign w_but1_fall = ~w_but1 & r_but1_prev;
    assign w_but2_rise = w_but2 & ~r_but2_prev;
    // Once HALT has been issued for this press, the release must stay silent.
    assign w_halt_evt  = w_but1 && (r_hold == HOLD_MAX) && !r_halt_done;
    assign w_run_evt   = w_but1_fall && !r_halt_done;

    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_but1_prev <= 1'b0;
            r_but2_prev <= 1'b0;
            r_hold      <= '0;
            r_halt_done <= 1'b0;
        end else begin
            r_but1_prev <= w_but1;
            r_but2_prev <= w_but2;
            if (!w_but1) begin
                r_hold      <= '0;
                r_halt_done <= 1'b0;
            end else begin
                if (r_hold != HOLD_MAX) r_hold <= r_hold + HOLD_W'(1);
                if (w_halt_evt) r_halt_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= StRst;
            r_seq_cnt <= '0;
            r_run     <= 1'b0;
            r_halt    <= 1'b0;
            r_reset   <= 1'b1;
            r_clear   <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_seq_cnt <= w_seq_cnt_next;
            r_run     <= w_run_next;
            r_halt    <= w_halt_next;
            r_reset   <= w_reset_next;
            r_clear   <= w_clear_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_seq_cnt_next = r_seq_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_but2_rise) begin
                    w_state_next   = StRst;
                    w_seq_cnt_next = '0;
                end
            end
            StRst: begin
                if (r_seq_cnt == RST_LAST) begin
                    w_state_next   = StClr;
                    w_seq_cnt_next = '0;
                end else begin
                    w_seq_cnt_next = r_seq_cnt + SEQ_W'(1);
                end
            end
            StClr: begin
                if (r_seq_cnt == CLR_LAST) begin
                    w_state_next   = StWaitRel;
                    w_seq_cnt_next = '0;
                end else begin
                    w_seq_cnt_next = r_seq_cnt + SEQ_W'(1);
                end
            end
            StWaitRel: begin
                if (!w_but2) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Pulses only leave while idle and not entering a sequence this cycle.
    always_comb begin
        w_idle_stays = (r_state == StIdle) && (w_state_next == StIdle);
        w_run_next   = w_run_evt && w_idle_stays;
        w_halt_next  = w_halt_evt && w_idle_stays;
        w_reset_next = (w_state_next == StRst);
        w_clear_next = (w_state_next == StClr);
        w_busy_next  = (w_state_next != StIdle);
    end

    assign sw_RUN   = r_run;
    assign sw_HALT  = r_halt;
    assign sw_RESET = r_reset;
    assign sw_CLEAR = r_clear;
    assign busy     = r_busy;

endmodule

// File: tb/tb_panel_switches.sv
// Directed bench for panel_switches with shortened timing parameters.
module tb_panel_switches;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic n_but1 = 1'b1;
    logic n_but2 = 1'b1;
    logic sw_run, sw_halt, sw_reset, sw_clear, busy;

    int checks = 0;
    int failures = 0;
    int idx, n_run, n_halt, n_rst, n_clr, n_busy, n_ovl, first_run, first_halt, first_clr;

    always #5 clk = ~clk;

    panel_switches #(
        .DEBOUNCE_CYCLES  (4),
        .LONGPRESS_CYCLES (20),
        .RESET_CYCLES     (3),
        .CLEAR_CYCLES     (2)
    ) dut (
        .SYSCLK   (clk),
        .nRESET   (n_reset),
        .nBUT1    (n_but1),
        .nBUT2    (n_but2),
        .sw_RUN   (sw_run),
        .sw_HALT  (sw_halt),
        .sw_RESET (sw_reset),
        .sw_CLEAR (sw_clear),
        .busy     (busy)
    );

    task automatic clear_mon();
        idx = 0; n_run = 0; n_halt = 0; n_rst = 0; n_clr = 0; n_busy = 0; n_ovl = 0;
        first_run = -1; first_halt = -1; first_clr = -1;
    endtask

    task automatic sample();
        if (sw_run) begin n_run++; if (first_run < 0) first_run = idx; end
        if (sw_halt) begin n_halt++; if (first_halt < 0) first_halt = idx; end
        if (sw_reset) n_rst++;
        if (sw_clear) begin n_clr++; if (first_clr < 0) first_clr = idx; end
        if (busy) n_busy++;
        if ((sw_reset && sw_clear) || (sw_run && sw_halt)) n_ovl++;
    endtask

    // Advance n rising edges, sampling 1 time unit after each.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            idx++;
            sample();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sw_reset !== 1'b1) begin failures++; $display("FAIL rst_sw_reset: got %b expected 1", sw_reset); end
        checks++; if (sw_clear !== 1'b0) begin failures++; $display("FAIL rst_sw_clear: got %b expected 0", sw_clear); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy: got %b expected 1", busy); end
        checks++; if (sw_run !== 1'b0) begin failures++; $display("FAIL rst_sw_run: got %b expected 0", sw_run); end
        checks++; if (sw_halt !== 1'b0) begin failures++; $display("FAIL rst_sw_halt: got %b expected 0", sw_halt); end
    endtask

    task automatic test_power_on();
        n_reset = 1'b1;
        clear_mon();
        sample();
        step(8);
        checks++; if (n_rst !== 3) begin failures++; $display("FAIL pon_reset_cycles: got %0d expected 3", n_rst); end
        checks++; if (n_clr !== 2) begin failures++; $display("FAIL pon_clear_cycles: got %0d expected 2", n_clr); end
        checks++; if (first_clr !== 3) begin failures++; $display("FAIL pon_clear_start: got %0d expected 3", first_clr); end
        checks++; if (n_busy !== 6) begin failures++; $display("FAIL pon_busy_cycles: got %0d expected 6", n_busy); end
        checks++; if ((n_run + n_halt) !== 0) begin failures++; $display("FAIL pon_pulses: got %0d expected 0", n_run + n_halt); end
        checks++; if (n_ovl !== 0) begin failures++; $display("FAIL pon_overlap: got %0d expected 0", n_ovl); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pon_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_short_press();
        clear_mon();
        n_but1 = 1'b0; step(3); n_but1 = 1'b1; step(15);
        checks++; if (n_run !== 0) begin failures++; $display("FAIL glitch_run: got %0d expected 0", n_run); end
        clear_mon();
        n_but1 = 1'b0; step(10); n_but1 = 1'b1; step(20);
        checks++; if (n_run !== 1) begin failures++; $display("FAIL press_run_count: got %0d expected 1", n_run); end
        checks++; if (first_run !== 17) begin failures++; $display("FAIL press_run_time: got %0d expected 17", first_run); end
        checks++; if (n_halt !== 0) begin failures++; $display("FAIL press_halt: got %0d expected 0", n_halt); end
    endtask

    task automatic test_long_press();
        clear_mon();
        n_but1 = 1'b0; step(40); n_but1 = 1'b1; step(20);
        checks++; if (n_halt !== 1) begin failures++; $display("FAIL long_halt_count: got %0d expected 1", n_halt); end
        checks++; if (first_halt !== 27) begin failures++; $display("FAIL long_halt_time: got %0d expected 27", first_halt); end
        checks++; if (n_run !== 0) begin failures++; $display("FAIL long_run: got %0d expected 0", n_run); end
        checks++; if (n_ovl !== 0) begin failures++; $display("FAIL long_overlap: got %0d expected 0", n_ovl); end
    endtask

    task automatic test_but2_hold();
        clear_mon();
        n_but2 = 1'b0; step(50); n_but2 = 1'b1; step(20);
        checks++; if (n_rst !== 3) begin failures++; $display("FAIL hold2_reset_cycles: got %0d expected 3", n_rst); end
        checks++; if (n_clr !== 2) begin failures++; $display("FAIL hold2_clear_cycles: got %0d expected 2", n_clr); end
        checks++; if (n_busy !== 50) begin failures++; $display("FAIL hold2_busy_cycles: got %0d expected 50", n_busy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold2_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_masked();
        clear_mon();
        n_but2 = 1'b0; step(2);
        n_but1 = 1'b0; step(6);
        n_but1 = 1'b1; step(2);
        n_but2 = 1'b1; step(30);
        checks++; if (n_run !== 0) begin failures++; $display("FAIL masked_run: got %0d expected 0", n_run); end
        checks++; if (n_halt !== 0) begin failures++; $display("FAIL masked_halt: got %0d expected 0", n_halt); end
        checks++; if (n_rst !== 3) begin failures++; $display("FAIL masked_reset_cycles: got %0d expected 3", n_rst); end
        checks++; if (n_clr !== 2) begin failures++; $display("FAIL masked_clear_cycles: got %0d expected 2", n_clr); end
    endtask

    // BUT1 release and BUT2 press land on the same debounced cycle.
    task automatic test_back_to_back();
        clear_mon();
        n_but1 = 1'b0; step(10);
        n_but1 = 1'b1; n_but2 = 1'b0; step(10);
        n_but2 = 1'b1; step(30);
        checks++; if (n_run !== 0) begin failures++; $display("FAIL same_cycle_run: got %0d expected 0", n_run); end
        checks++; if (n_rst !== 3) begin failures++; $display("FAIL same_cycle_reset: got %0d expected 3", n_rst); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL same_cycle_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        n_but2 = 1'b0; step(10); n_but2 = 1'b1;
        checks++; if (sw_clear !== 1'b1) begin failures++; $display("FAIL mid_in_clear: got %b expected 1", sw_clear); end
        #1 n_reset = 1'b0;
        #1;
        checks++; if (sw_reset !== 1'b1) begin failures++; $display("FAIL mid_sw_reset: got %b expected 1", sw_reset); end
        checks++; if (sw_clear !== 1'b0) begin failures++; $display("FAIL mid_sw_clear: got %b expected 0", sw_clear); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", busy); end
        #1 n_reset = 1'b1;
        clear_mon();
        sample();
        step(8);
        checks++; if (n_rst !== 3) begin failures++; $display("FAIL mid_reset_cycles: got %0d expected 3", n_rst); end
        checks++; if (n_clr !== 2) begin failures++; $display("FAIL mid_clear_cycles: got %0d expected 2", n_clr); end
        checks++; if (first_clr !== 3) begin failures++; $display("FAIL mid_clear_start: got %0d expected 3", first_clr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_end: got %b expected 0", busy); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_power_on();
        test_short_press();
        test_long_press();
        test_but2_hold();
        test_masked();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
